product_accumulator: RTL and testbench
======================================

# product_accumulator

Streaming signed accumulate stage that sits directly downstream of the 4-bit signed multiplier. It consumes the multiplier's 8-bit two's-complement product P through a valid/ready handshake and sums LEN consecutive products with per-step saturation. It presents the resulting dot-product word, plus a sticky saturation flag, on an output valid/ready handshake. The output is held until it is consumed.

## Interface
- PROD_W, 8, product width (signed; matches multiplier P).
- ACC_W, 12, accumulator/result width (signed); must be ≥ PROD_W.
- LEN, 4, number of products per group; legal range 1..255.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous abort; discards the current group.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block accepts in_prod this cycle.
- in_prod  input  PROD_W  signed product from the multiplier.
- out_valid  output  1  out_data/out_sat hold a finished group.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  signed saturated group sum.
- out_sat  output  1  at least one clamp occurred within the group.

## Operation
- There are two states, ACC and DONE. After reset the block is in ACC.
- in_ready = (state == ACC). It is combinational from state only and never depends on in_valid.
- Accept: in_valid && in_ready. On accept:
  - in_prod is sign-extended to ACC_W+1 bits and added to the sign-extended acc.
  - The sum is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - If the clamp changed the value, sat_acc is set.
  - cnt increments.
- Saturation is applied per step, not once at the end. After clamping, later products add to the clamped value.
- When cnt == LEN-1 on an accept:
  - The clamped sum is loaded into out_data and sat_acc|clamp into out_sat.
  - acc, cnt and sat_acc are zeroed.
  - State goes to DONE, so out_valid=1 on the next cycle.
- DONE: out_valid=1 and in_ready=0. out_data and out_sat remain stable until out_valid && out_ready. On that handshake the state returns to ACC and out_valid=0 on the next cycle.
- clear=1 (either state):
  - Next cycle the state is ACC, with acc=0, cnt=0, sat_acc=0, out_valid=0.
  - An input accept or output handshake in the same cycle is ignored.
  - clear has priority over everything except rst.
- in_prod is don't-care when in_valid=0. Idle cycles (in_valid=0) do not advance cnt.

## Timing
- Reset values: state=ACC, in_ready=1, out_valid=0, out_data=0, out_sat=0, acc=0, cnt=0, sat_acc=0. These take effect immediately on rst assertion, independent of clk.
- Reset mid-group or while in DONE: the partial sum and the pending result are lost. No output handshake completes.
- Throughput:
  - One product per cycle while in ACC.
  - The result appears 1 cycle after the accept of the LEN-th product.
  - At least one bubble occurs per group: in_ready=0 for every DONE cycle, minimum 1.
- No bypass: with out_ready held at 1, DONE lasts exactly 1 cycle. Group period is LEN+1 cycles.
- LEN=1: every accept goes straight to DONE, and out_data = clamp(in_prod).
- out_ready while out_valid=0 has no effect.
- in_valid while in_ready=0 has no effect. The producer must hold in_prod until it is accepted.

## Test plan
- Default parameters; stream 0x00, 0xFD, 0x31, 0x07 (0, -3, 49, 7) with in_valid held high and out_ready=1. Expect out_valid high exactly 1 cycle after the 4th accept, out_data=0x035 (53), out_sat=0, in_ready=0 for that one cycle, then 1 again.
- Default parameters; stream 0xCF, 0xCF, 0x0E, 0x00 (-49, -49, 14, 0). Expect out_data=0xFAC (-84), out_sat=0. Then hold out_ready=0 for 5 cycles: out_valid and out_data stay stable and in_ready stays 0. Release out_ready: exactly one handshake completes, and in_ready=1 on the next cycle.
- ACC_W=8; stream 0x40, 0x40, 0x40, 0xC0 (64, 64, 64, -64). The steps clamp at 127 after the 2nd product, stay at 127 after the 3rd, and reach 63 after the 4th. Expect out_data=0x3F, out_sat=1. A following group 1, 1, 1, 1 gives out_data=0x04 and out_sat=0, showing the flag does not leak between groups.
- Default parameters; accept 2 products (0x10, 0x10) with idle cycles between them, then pulse clear together with in_valid and in_prod=0x10. The clear-cycle product must not be counted. Then accept 4× 0x01: expect out_data=0x004.
- Assert rst asynchronously (between clock edges) while in DONE with out_data=0x035. Expect out_valid=0, out_data=0, out_sat=0 and in_ready=1 immediately, before the next clk edge. After release, a fresh 4-product group accumulates from zero.
- LEN=1; stream 0x80, 0x7F back-to-back with out_ready=1. Expect results 0xF80 then 0x07F, out_sat=0, and a 2-cycle group period.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Valid/ready bus around the product accumulator: product stream in, group result out.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_sat;

    modport slave (
        input  in_valid,
        input  in_prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat
    );

    modport master (
        output in_valid,
        output in_prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums LEN signed products with per-step saturation and holds the result until consumed.
// A sticky flag reports whether any step of the group clamped.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int LEN    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    product_accumulator_if.slave   bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ST_ACC, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_acc_q, sat_acc_d;
    logic [ACC_W-1:0]  data_q, data_d;
    logic              out_sat_q, out_sat_d;

    logic [ACC_W:0]    sum_ext;
    logic              overflow;
    logic [ACC_W-1:0]  clamped;
    logic              accept;
    logic              consume;

    // One guard bit is enough: a product never exceeds the accumulator range.
    assign sum_ext  = {acc_q[ACC_W-1], acc_q}
                    + {{(ACC_W+1-PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
    assign overflow = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    assign clamped  = overflow ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX)
                               : sum_ext[ACC_W-1:0];

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_sat   = out_sat_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_acc_d = sat_acc_q;
        data_d    = data_q;
        out_sat_d = out_sat_q;

        if (clear) begin
            state_d   = ST_ACC;
            acc_d     = '0;
            cnt_d     = '0;
            sat_acc_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (cnt_q == LAST_CNT) begin
                            data_d    = clamped;
                            out_sat_d = sat_acc_q | overflow;
                            acc_d     = '0;
                            cnt_d     = '0;
                            sat_acc_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            acc_d     = clamped;
                            cnt_d     = cnt_q + CNT_W'(1);
                            sat_acc_d = sat_acc_q | overflow;
                        end
                    end
                end
                ST_DONE: begin
                    if (consume) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_acc_q <= 1'b0;
            data_q    <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_acc_q <= sat_acc_d;
            data_q    <= data_d;
            out_sat_q <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default, narrow (ACC_W=8) and LEN=1 instances
// share one stimulus set; checks target whichever instance is selected.
module tb_product_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_prod = 8'h00;
    logic       out_ready = 1'b0;
    int         sel = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(8), .ACC_W(12)) if_a ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(8))  if_b ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(12)) if_c ();

    assign if_a.in_valid = in_valid;  assign if_a.in_prod = in_prod;  assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid;  assign if_b.in_prod = in_prod;  assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid;  assign if_c.in_prod = in_prod;  assign if_c.out_ready = out_ready;

    product_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(4)) dut_a (.clk(clk), .rst(rst), .clear(clear), .bus(if_a));
    product_accumulator #(.PROD_W(8), .ACC_W(8),  .LEN(4)) dut_b (.clk(clk), .rst(rst), .clear(clear), .bus(if_b));
    product_accumulator #(.PROD_W(8), .ACC_W(12), .LEN(1)) dut_c (.clk(clk), .rst(rst), .clear(clear), .bus(if_c));

    logic        ir_m, ov_m, os_m;
    logic [11:0] od_m;
    always_comb begin
        ir_m = if_a.in_ready;  ov_m = if_a.out_valid;  od_m = if_a.out_data;  os_m = if_a.out_sat;
        if (sel == 1) begin
            ir_m = if_b.in_ready;  ov_m = if_b.out_valid;  od_m = {4'h0, if_b.out_data};  os_m = if_b.out_sat;
        end else if (sel == 2) begin
            ir_m = if_c.in_ready;  ov_m = if_c.out_valid;  od_m = if_c.out_data;  os_m = if_c.out_sat;
        end
    end

    typedef struct {
        logic       clr;
        logic       v;
        logic [7:0] p;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [11:0] e_od;
        logic       e_os;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic clr, input logic v, input logic [7:0] p, input logic ordy,
                       input logic e_ir, input logic e_ov, input logic [11:0] e_od, input logic e_os);
        vec_t r;
        r = '{clr, v, p, ordy, e_ir, e_ov, e_od, e_os};
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;  in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Enters and leaves on a falling edge; holds in_prod until the selected DUT accepts it.
    task automatic push(input logic [7:0] p);
        bit done = 0;
        in_valid = 1'b1;  in_prod = p;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (ir_m) done = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            errors++;  checks++;
            $display("FAIL push %h: in_ready timeout", p);
        end
    endtask

    task automatic expect_out(input string name, input logic [11:0] e_od, input logic e_os);
        bit seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (ov_m) begin
                seen = 1;
                chk({name, " data"}, od_m, e_od);
                chk({name, " sat"}, {11'h0, os_m}, {11'h0, e_os});
            end
            @(negedge clk);
        end
        if (!seen) begin
            errors++;  checks++;
            $display("FAIL %s: out_valid timeout", name);
        end
    endtask

    initial begin
        // Group 0+(-3)+49+7 = 53 with streaming output
        add(0,1,8'h00,1, 1,0,12'h000,0);
        add(0,1,8'hFD,1, 1,0,12'h000,0);
        add(0,1,8'h31,1, 1,0,12'h000,0);
        add(0,1,8'h07,1, 1,0,12'h000,0);
        add(0,1,8'h00,1, 0,1,12'h035,0);
        add(0,0,8'h00,1, 1,0,12'h000,0);
        // Group -49-49+14+0 = -84, then five stalled cycles
        add(0,1,8'hCF,0, 1,0,12'h000,0);
        add(0,1,8'hCF,0, 1,0,12'h000,0);
        add(0,1,8'h0E,0, 1,0,12'h000,0);
        add(0,1,8'h00,0, 1,0,12'h000,0);
        for (int i = 0; i < 5; i++) add(0,0,8'h00,0, 0,1,12'hFAC,0);
        add(0,0,8'h00,1, 0,1,12'hFAC,0);
        add(0,0,8'h00,1, 1,0,12'h000,0);
        // Two accepts with gaps, clear with a product present, then 4x 1
        add(0,1,8'h10,1, 1,0,12'h000,0);
        add(0,0,8'h00,1, 1,0,12'h000,0);
        add(0,1,8'h10,1, 1,0,12'h000,0);
        add(0,0,8'h00,1, 1,0,12'h000,0);
        add(1,1,8'h10,1, 1,0,12'h000,0);
        for (int i = 0; i < 4; i++) add(0,1,8'h01,1, 1,0,12'h000,0);
        add(0,0,8'h00,1, 0,1,12'h004,0);
        add(0,0,8'h00,1, 1,0,12'h000,0);
        // Clear while DONE overrides the handshake and drops the result
        for (int i = 0; i < 4; i++) add(0,1,8'h01,0, 1,0,12'h000,0);
        add(1,0,8'h00,1, 0,1,12'h004,0);
        add(0,0,8'h00,1, 1,0,12'h000,0);

        #3;
        chk("reset in_ready", {11'h0, if_a.in_ready}, 12'h001);
        chk("reset out_valid", {11'h0, if_a.out_valid}, 12'h000);
        chk("reset out_data", if_a.out_data, 12'h000);
        chk("reset out_sat", {11'h0, if_a.out_sat}, 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        sel = 0;
        foreach (tbl[k]) begin
            @(negedge clk);
            clear = tbl[k].clr;  in_valid = tbl[k].v;  in_prod = tbl[k].p;  out_ready = tbl[k].ordy;
            #1;
            chk($sformatf("row%0d in_ready", k), {11'h0, ir_m}, {11'h0, tbl[k].e_ir});
            chk($sformatf("row%0d out_valid", k), {11'h0, ov_m}, {11'h0, tbl[k].e_ov});
            if (tbl[k].e_ov) begin
                chk($sformatf("row%0d out_data", k), od_m, tbl[k].e_od);
                chk($sformatf("row%0d out_sat", k), {11'h0, os_m}, {11'h0, tbl[k].e_os});
            end
        end

        // Narrow accumulator: per-step clamp at 127, then a clean group
        pulse_clear();
        sel = 1;  out_ready = 1'b1;
        push(8'h40); push(8'h40); push(8'h40); push(8'hC0);
        expect_out("acc8 sat group", 12'h03F, 1'b1);
        push(8'h01); push(8'h01); push(8'h01); push(8'h01);
        expect_out("acc8 clean group", 12'h004, 1'b0);

        // LEN=1: two-cycle period with out_ready held high
        pulse_clear();
        sel = 2;  out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;  in_prod = 8'h80;
        #1;
        chk("len1 c0 in_ready", {11'h0, ir_m}, 12'h001);
        chk("len1 c0 out_valid", {11'h0, ov_m}, 12'h000);
        @(negedge clk);
        in_prod = 8'h7F;
        #1;
        chk("len1 c1 in_ready", {11'h0, ir_m}, 12'h000);
        chk("len1 c1 out_valid", {11'h0, ov_m}, 12'h001);
        chk("len1 c1 out_data", od_m, 12'hF80);
        chk("len1 c1 out_sat", {11'h0, os_m}, 12'h000);
        @(negedge clk);
        #1;
        chk("len1 c2 in_ready", {11'h0, ir_m}, 12'h001);
        chk("len1 c2 out_valid", {11'h0, ov_m}, 12'h000);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("len1 c3 out_valid", {11'h0, ov_m}, 12'h001);
        chk("len1 c3 out_data", od_m, 12'h07F);
        chk("len1 c3 out_sat", {11'h0, os_m}, 12'h000);
        @(negedge clk);
        #1;
        chk("len1 c4 in_ready", {11'h0, ir_m}, 12'h001);

        // Asynchronous reset while a result is pending
        pulse_clear();
        sel = 0;  out_ready = 1'b0;
        push(8'h00); push(8'hFD); push(8'h31); push(8'h07);
        #1;
        chk("pre-rst out_valid", {11'h0, ov_m}, 12'h001);
        chk("pre-rst out_data", od_m, 12'h035);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst in_ready", {11'h0, ir_m}, 12'h001);
        chk("async rst out_valid", {11'h0, ov_m}, 12'h000);
        chk("async rst out_data", od_m, 12'h000);
        chk("async rst out_sat", {11'h0, os_m}, 12'h000);
        #1;
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        expect_out("post-rst group", 12'h00A, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
